// File: rtl/wb_arbiter.sv
// Writeback arbiter: accepts ALU and mul/div results into a small in-order FIFO
// and retires one entry per cycle to the register file, with source busy flags.
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     md_valid,
    input  logic [ADDR_W-1:0]        md_addr,
    input  logic [DATA_W-1:0]        md_data,
    output logic                     md_ready,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_data,
    input  logic [ADDR_W-1:0]        q_addr_a,
    input  logic [ADDR_W-1:0]        q_addr_b,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [CW-1:0]     count_r;
    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_addr_r;
    logic [DATA_W-1:0] rf_data_r;

    logic [CW-1:0]     free_s;
    logic              alu_push_s;
    logic              md_push_s;
    logic              pop_s;
    logic [PW-1:0]     md_slot_s;
    logic              hit_a_s;
    logic              hit_b_s;

    // Credit comes from the registered count only, so a pop in the same cycle
    // never frees a slot for an incoming offer.
    assign free_s    = CW'(DEPTH) - count_r;
    assign md_ready  = (free_s >= CW'(1));
    assign alu_ready = (free_s >= CW'(2)) || ((free_s == CW'(1)) && !md_valid);

    // Register 0 writes complete the handshake but never occupy a slot.
    assign alu_push_s = alu_valid && alu_ready && (alu_addr != {ADDR_W{1'b0}});
    assign md_push_s  = md_valid && md_ready && (md_addr != {ADDR_W{1'b0}});
    assign pop_s      = (count_r != {CW{1'b0}});
    assign md_slot_s  = wr_ptr_r + PW'(alu_push_s);

    // FIFO storage: ALU entry lands first, mul/div right behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ADDR_W{1'b0}};
                data_mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (alu_push_s) begin
                addr_mem_r[wr_ptr_r] <= alu_addr;
                data_mem_r[wr_ptr_r] <= alu_data;
            end
            if (md_push_s) begin
                addr_mem_r[md_slot_s] <= md_addr;
                data_mem_r[md_slot_s] <= md_data;
            end
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r  <= {PW{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            rf_we_r   <= 1'b0;
            rf_addr_r <= {ADDR_W{1'b0}};
            rf_data_r <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + PW'(alu_push_s) + PW'(md_push_s);
            count_r  <= count_r + CW'(alu_push_s) + CW'(md_push_s) - CW'(pop_s);
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + PW'(1);
                rf_we_r   <= 1'b1;
                rf_addr_r <= addr_mem_r[rd_ptr_r];
                rf_data_r <= data_mem_r[rd_ptr_r];
            end else begin
                rf_we_r   <= 1'b0;
            end
        end
    end

    // Match decode sources against every occupied FIFO slot.
    always_comb begin
        hit_a_s = 1'b0;
        hit_b_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(i) - rd_ptr_r} < count_r) begin
                if (addr_mem_r[i] == q_addr_a) begin
                    hit_a_s = 1'b1;
                end else begin
                    hit_a_s = hit_a_s;
                end
                if (addr_mem_r[i] == q_addr_b) begin
                    hit_b_s = 1'b1;
                end else begin
                    hit_b_s = hit_b_s;
                end
            end else begin
                hit_a_s = hit_a_s;
                hit_b_s = hit_b_s;
            end
        end
    end

    assign busy_a = (q_addr_a != {ADDR_W{1'b0}}) &&
                    (hit_a_s || (rf_we_r && (rf_addr_r == q_addr_a)));
    assign busy_b = (q_addr_b != {ADDR_W{1'b0}}) &&
                    (hit_b_s || (rf_we_r && (rf_addr_r == q_addr_b)));

    assign rf_we   = rf_we_r;
    assign rf_addr = rf_addr_r;
    assign rf_data = rf_data_r;
    assign count   = count_r;
    assign empty   = (count_r == {CW{1'b0}});
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a queue-based model of the writeback FIFO checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, md_valid = 1'b0;
    logic [4:0]  alu_addr = 5'd0, md_addr = 5'd0, q_addr_a = 5'd0, q_addr_b = 5'd0;
    logic [31:0] alu_data = 32'd0, md_data = 32'd0;
    logic        alu_ready, md_ready, rf_we, busy_a, busy_b, empty;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [2:0]  count;

    wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .q_addr_a(q_addr_a), .q_addr_b(q_addr_b), .busy_a(busy_a), .busy_b(busy_b),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } entry_t;
    entry_t      q[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;
    logic        e_alu, e_md;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_busy(input logic [4:0] qa);
        logic hit = 1'b0;
        foreach (q[i]) if (q[i].a == qa) hit = 1'b1;
        return (qa != 5'd0) && (hit || (m_we && m_addr == qa));
    endfunction

    // Drive one cycle of inputs at negedge, then compare every output to the model.
    task automatic drive_check(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic [4:0] qa, input logic [4:0] qb);
        int free;
        @(negedge clk);
        rst = 1'b0;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        md_valid = mv; md_addr = ma; md_data = md;
        q_addr_a = qa; q_addr_b = qb;
        #1;
        free  = DEPTH - q.size();
        e_md  = (free >= 1);
        e_alu = (free >= 2) || (free == 1 && !mv);
        vectors++;
        chk("md_ready", {31'd0, md_ready}, {31'd0, e_md});
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, e_alu});
        chk("count", {29'd0, count}, q.size());
        chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
        chk("busy_a", {31'd0, busy_a}, {31'd0, model_busy(qa)});
        chk("busy_b", {31'd0, busy_b}, {31'd0, model_busy(qb)});
        chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
        chk("rf_addr", {27'd0, rf_addr}, {27'd0, m_addr});
        chk("rf_data", rf_data, m_data);
    endtask

    // Apply the posedge to the model: retire the head, then enqueue ALU then mul/div.
    task automatic advance();
        if (rst) begin
            q.delete(); m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        end else begin
            if (q.size() > 0) begin
                entry_t h = q.pop_front();
                m_we = 1'b1; m_addr = h.a; m_data = h.d;
            end else begin
                m_we = 1'b0;
            end
            if (alu_valid && e_alu && alu_addr != 5'd0) q.push_back({alu_addr, alu_data});
            if (md_valid && e_md && md_addr != 5'd0) q.push_back({md_addr, md_data});
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic [4:0] qa);
        drive_check(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa, 5'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        // Reset values while still in reset.
        #1;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_ready", {30'd0, alu_ready, md_ready}, 32'd3);

        // Reset mid-stream with three entries queued.
        drive_check(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd1, 5'd2); advance();
        drive_check(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 5'd3, 5'd4); advance();
        idle(5'd4);
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("midrst_count", {29'd0, count}, 32'd0);
        chk("midrst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        advance();
        repeat (3) begin idle(5'd3); advance(); end

        // Single ALU write to R5.
        drive_check(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0); advance();
        idle(5'd5);
        chk("single_busy1", {31'd0, busy_a}, 32'd1);
        chk("single_we0", {31'd0, rf_we}, 32'd0);
        advance();
        idle(5'd5);
        chk("single_busy2", {31'd0, busy_a}, 32'd1);
        chk("single_we", {31'd0, rf_we}, 32'd1);
        chk("single_addr", {27'd0, rf_addr}, 32'd5);
        chk("single_data", rf_data, 32'hDEADBEEF);
        advance();
        idle(5'd5);
        chk("single_busy_drop", {31'd0, busy_a}, 32'd0);
        advance();

        // Dual accept to R3 retires ALU first.
        drive_check(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd0);
        chk("dual_ready", {30'd0, alu_ready, md_ready}, 32'd3);
        advance();
        idle(5'd3); advance();
        idle(5'd3);
        chk("dual_first", rf_data, 32'h11);
        advance();
        idle(5'd3);
        chk("dual_second", rf_data, 32'h22);
        chk("dual_addr", {27'd0, rf_addr}, 32'd3);
        advance();
        idle(5'd3); advance();

        // Priority with a single free slot.
        drive_check(1'b1, 5'd6, 32'h61, 1'b1, 5'd7, 32'h71, 5'd6, 5'd7); advance();
        drive_check(1'b1, 5'd8, 32'h81, 1'b1, 5'd9, 32'h91, 5'd8, 5'd9); advance();
        drive_check(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 5'd10, 5'd11);
        chk("prio_count", {29'd0, count}, 32'd3);
        chk("prio_md_ready", {31'd0, md_ready}, 32'd1);
        chk("prio_alu_ready", {31'd0, alu_ready}, 32'd0);
        advance();
        drive_check(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
        chk("prio_alu_late", {31'd0, alu_ready}, 32'd1);
        advance();
        repeat (6) begin idle(5'd10); advance(); end

        // Both producers hammering a full FIFO across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            drive_check(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1,
                        5'($urandom_range(1, 31)), $urandom,
                        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            chk("full_count_max", {31'd0, count <= 3'd4}, 32'd1);
            advance();
        end
        repeat (6) begin idle(5'd0); advance(); end
        idle(5'd0);
        chk("drained_empty", {31'd0, empty}, 32'd1);
        advance();

        // Register 0 is accepted but dropped.
        drive_check(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("r0_ready", {31'd0, alu_ready}, 32'd1);
        advance();
        idle(5'd0);
        chk("r0_count", {29'd0, count}, 32'd0);
        chk("r0_busy", {31'd0, busy_a}, 32'd0);
        advance();
        idle(5'd0);
        chk("r0_no_we", {31'd0, rf_we}, 32'd0);
        advance();

        // Steady state at count 2 with one push and one pop per cycle.
        drive_check(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, 5'd12, 5'd13); advance();
        for (int i = 0; i < 10; i++) begin
            drive_check(1'b1, 5'(14 + i), 32'h100 + i, 1'b0, 5'd0, 32'd0, 5'(14 + i), 5'd13);
            chk("steady_count", {29'd0, count}, 32'd2);
            advance();
        end
        repeat (4) begin idle(5'd0); advance(); end

        // Random traffic over a narrow address range to exercise busy hits.
        for (int i = 0; i < 400; i++) begin
            drive_check(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and queue between the result producers and the register file write port. It accepts results from the single-cycle ALU path and the multi-cycle multiply/divide unit over valid/ready handshakes and buffers them in a small in-order FIFO. It drains one entry per cycle into the register file's `Write_Enable`/`Write_Addr`/`Data_in` inputs. It also reports per-operand busy flags to the decode-stage hazard logic.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `DATA_W`, 32: result width.
- `ADDR_W`, 5: register address width.

- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `alu_valid` in 1: ALU result offered.
- `alu_addr` in ADDR_W: ALU destination register.
- `alu_data` in DATA_W: ALU result.
- `alu_ready` out 1: ALU offer accepted this cycle when high with `alu_valid`.
- `md_valid`, `md_addr`, `md_data`, `md_ready`: same roles for the mul/div unit.
- `rf_we` out 1: drives register file `Write_Enable`.
- `rf_addr` out ADDR_W: drives `Write_Addr`.
- `rf_data` out DATA_W: drives `Data_in`.
- `q_addr_a`, `q_addr_b` in ADDR_W: decode source registers to check.
- `busy_a`, `busy_b` out 1: a write to that register is queued or in flight.
- `count` out log2(DEPTH)+1: occupied FIFO entries.
- `empty` out 1: `count == 0`.

## Operation
- **Free slots.** `free = DEPTH - count`, computed from the registered count only. A same-cycle pop gives no credit.
- **Ready rules (combinational):**
  - `md_ready = (free >= 1)`.
  - `alu_ready = (free >= 2) || (free == 1 && !md_valid)`.
  - When only one slot is free, mul/div has fixed priority.
- **Accept.** A handshake occurs when valid && ready.
  - Both accepted in the same cycle: the ALU entry is enqueued first, then mul/div.
- **Register 0.** An accepted offer with addr 0 completes the handshake but is discarded: not enqueued, not counted.
- **Pop.** Each posedge with `count > 0`, the head is popped:
  - `rf_we <= 1`, `rf_addr <= head.addr`, `rf_data <= head.data`.
  - Otherwise `rf_we <= 0`, and `rf_addr`/`rf_data` hold their values.
- **Simultaneous events.** Push(es) and pop in the same cycle are legal.
  - `count_next = count + pushes - pop`, with pushes in 0..2.
  - Pointers wrap modulo DEPTH.
- **Order.** Entries retire strictly in acceptance order. Two queued writes to the same register retire in order, so the last one wins.
- **Busy.** `busy_x = (q_addr_x != 0) && (any valid FIFO entry has addr == q_addr_x || (rf_we && rf_addr == q_addr_x))`. This is combinational.
  - Offers not yet accepted are not included; stalling on those is the producer's responsibility.
- **Reset (asynchronous, any time).**
  - Pointers and count clear; all queued writes are discarded.
  - `rf_we=0`, `rf_addr=0`, `rf_data=0`, `count=0`, `empty=1`.
  - `busy_a=busy_b=0`.
  - The ready outputs follow from count=0 (`md_ready=1`, `alu_ready=1`).

## Timing
- **Latency into an empty FIFO.** Accepted at posedge N → `rf_we` high from posedge N+1 to N+2. The register file captures the write at the negedge inside that cycle.
- **Read-back.** A source read of that register after that negedge returns the new value. `busy` drops at posedge N+2, provided no other entry matches.
- **Throughput.** One retire per cycle; up to two accepts per cycle.
- **Full FIFO.** Both ready outputs are low. The cycle after a pop, `md_ready` rises.
- **Input timing.** Ready outputs depend only on `count` and `md_valid`. There is no combinational path from `alu_valid` to any output.

## Test plan
- **Reset and single ALU write.** Reset mid-stream with 3 entries queued → `count=0`, `rf_we=0` immediately, and no further writes. Then ALU offers addr 5 / 0xDEADBEEF → `rf_we=1`, `rf_addr=5`, `rf_data=0xDEADBEEF` exactly one cycle later. `busy` for q_addr 5 is high for 2 cycles.
- **Dual accept and ordering.** Empty FIFO; ALU (addr 3, 0x11) and mul/div (addr 3, 0x22) offered in the same cycle → both ready. Retires 0x11 then 0x22 on consecutive cycles; final R3 = 0x22.
- **Priority at one free slot.** Fill to DEPTH-1, then offer both → `md_ready=1`, `alu_ready=0`. The ALU entry is accepted the next cycle after a pop. Contents retire in order.
- **Full/wrap.** Hold both producers valid for 20 cycles with random addrs 1..31 → `count` never exceeds 4. No entry lost or duplicated across pointer wrap (scoreboard check). `empty=1` after draining.
- **Register 0.** ALU offers addr 0 / 0xFFFFFFFF → `alu_ready=1` and `count` unchanged. `rf_we` never asserts for it. `busy` for q_addr 0 stays 0.
- **Same-cycle push/pop.** With `count=2` steady-state, do one push and one pop every cycle for 10 cycles → `count` stays 2 and data retires in order.
